// File: rtl/niski_dut.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : niski_dut                                                       |
// | Desc     : Board bring-up block: button sync/LEDs, 32-bit step counter on  |
// |            a 4-digit 7-seg display, optional HD44780 init (NISKI_LCD_EN).  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module niski_dut #(
    parameter logic [31:0] RESET_PC    = 32'h4000_0000,
    parameter logic [31:0] END_ADDR    = 32'h4000_0538,
    parameter int          REFRESH_DIV = 16,
    parameter int          LCD_DELAY   = 16,
    parameter int          E_CYCLES    = 4
) (
    input  logic       CLK_PIN,
    input  logic [4:0] BTN_PINS,
    output logic [3:0] LED_PINS,
    output logic [6:0] SEVSEG_SEG_PINS,
    output logic [3:0] SEVSEG_SEL_PINS,
    output logic       LCD_RS_PIN,
    output logic       LCD_RW_PIN,
    output logic       LCD_E_PIN,
    output logic [7:0] LCD_DATA_PINS
);

    localparam int c_DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    generate
        if (REFRESH_DIV < 2 || LCD_DELAY < 1 || E_CYCLES < 1 ||
            LCD_DELAY > 65535 || E_CYCLES > 65535) begin : g_bad_cfg
            $error("niski_dut: timing parameters out of range");
        end
    endgenerate

    // Reset asserts asynchronously from the pin, deasserts on a clock edge.
    logic       w_rst_pin_n;
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    assign w_rst_pin_n = BTN_PINS[4];

    always_ff @(posedge CLK_PIN or negedge w_rst_pin_n) begin
        if (!w_rst_pin_n) r_rst_sync <= 2'b00;
        else              r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    logic [3:0] r_btn_meta;
    logic [3:0] r_btn_sync;

    always_ff @(posedge CLK_PIN or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_btn_meta <= 4'hF;
            r_btn_sync <= 4'hF;
        end else begin
            r_btn_meta <= BTN_PINS[3:0];
            r_btn_sync <= r_btn_meta;
        end
    end

    assign LED_PINS = ~r_btn_sync;

    logic [31:0] r_pc;

    always_ff @(posedge CLK_PIN or negedge w_rst_n) begin
        if (!w_rst_n)                               r_pc <= RESET_PC;
        else if (r_btn_sync[3] && r_pc != END_ADDR) r_pc <= r_pc + 32'd4;
    end

    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_digit;

    always_ff @(posedge CLK_PIN or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_div   <= '0;
            r_digit <= 2'd0;
        end else if (r_div == c_DIV_W'(REFRESH_DIV - 1)) begin
            r_div   <= '0;
            r_digit <= r_digit + 2'd1;
        end else begin
            r_div   <= r_div + 1'b1;
        end
    end

    logic [3:0] w_nibble;
    logic [6:0] w_seg;
    logic [3:0] w_sel;

    always_comb begin
        w_nibble = r_pc[3:0];
        case (r_digit)
            2'd0:    w_nibble = r_pc[3:0];
            2'd1:    w_nibble = r_pc[7:4];
            2'd2:    w_nibble = r_pc[11:8];
            default: w_nibble = r_pc[15:12];
        endcase
    end

    // Active-low segments, {g,f,e,d,c,b,a}.
    always_comb begin
        w_seg = 7'b1111111;
        case (w_nibble)
            4'h0: w_seg = 7'b1000000;
            4'h1: w_seg = 7'b1111001;
            4'h2: w_seg = 7'b0100100;
            4'h3: w_seg = 7'b0110000;
            4'h4: w_seg = 7'b0011001;
            4'h5: w_seg = 7'b0010010;
            4'h6: w_seg = 7'b0000010;
            4'h7: w_seg = 7'b1111000;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0010000;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b0000011;
            4'hC: w_seg = 7'b1000110;
            4'hD: w_seg = 7'b0100001;
            4'hE: w_seg = 7'b0000110;
            default: w_seg = 7'b0001110;
        endcase
    end

    always_comb begin
        w_sel          = 4'b1111;
        w_sel[r_digit] = 1'b0;
    end

    assign SEVSEG_SEG_PINS = w_seg;
    assign SEVSEG_SEL_PINS = w_sel;
    assign LCD_RW_PIN      = 1'b0;

`ifdef NISKI_LCD_EN
    localparam logic [2:0] c_ST_PWR_WAIT = 3'd0;
    localparam logic [2:0] c_ST_SETUP    = 3'd1;
    localparam logic [2:0] c_ST_PULSE    = 3'd2;
    localparam logic [2:0] c_ST_HOLD     = 3'd3;
    localparam logic [2:0] c_ST_DONE     = 3'd4;

    logic [2:0]  r_lcd_state;
    logic [15:0] r_lcd_cnt;
    logic [1:0]  r_cmd_idx;
    logic        r_lcd_e;
    logic        r_lcd_rs;
    logic [7:0]  r_lcd_data;

    function automatic logic [7:0] f_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    f_cmd = 8'h38;
            2'd1:    f_cmd = 8'h0C;
            2'd2:    f_cmd = 8'h06;
            default: f_cmd = 8'h01;
        endcase
    endfunction

    // Data/RS are loaded on entry to SETUP and only change on leaving HOLD.
    always_ff @(posedge CLK_PIN or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_lcd_state <= c_ST_PWR_WAIT;
            r_lcd_cnt   <= 16'd0;
            r_cmd_idx   <= 2'd0;
            r_lcd_e     <= 1'b0;
            r_lcd_rs    <= 1'b0;
            r_lcd_data  <= 8'h00;
        end else begin
            case (r_lcd_state)
                c_ST_PWR_WAIT: begin
                    if (r_lcd_cnt == 16'(LCD_DELAY - 1)) begin
                        r_lcd_cnt   <= 16'd0;
                        r_cmd_idx   <= 2'd0;
                        r_lcd_rs    <= 1'b0;
                        r_lcd_data  <= f_cmd(2'd0);
                        r_lcd_state <= c_ST_SETUP;
                    end else begin
                        r_lcd_cnt <= r_lcd_cnt + 16'd1;
                    end
                end
                c_ST_SETUP: begin
                    r_lcd_e     <= 1'b1;
                    r_lcd_cnt   <= 16'd0;
                    r_lcd_state <= c_ST_PULSE;
                end
                c_ST_PULSE: begin
                    if (r_lcd_cnt == 16'(E_CYCLES - 1)) begin
                        r_lcd_e     <= 1'b0;
                        r_lcd_cnt   <= 16'd0;
                        r_lcd_state <= c_ST_HOLD;
                    end else begin
                        r_lcd_cnt <= r_lcd_cnt + 16'd1;
                    end
                end
                c_ST_HOLD: begin
                    if (r_lcd_cnt == 16'(LCD_DELAY - 1)) begin
                        r_lcd_cnt <= 16'd0;
                        if (r_cmd_idx == 2'd3) begin
                            r_lcd_rs    <= 1'b0;
                            r_lcd_data  <= 8'h00;
                            r_lcd_state <= c_ST_DONE;
                        end else begin
                            r_cmd_idx   <= r_cmd_idx + 2'd1;
                            r_lcd_data  <= f_cmd(r_cmd_idx + 2'd1);
                            r_lcd_state <= c_ST_SETUP;
                        end
                    end else begin
                        r_lcd_cnt <= r_lcd_cnt + 16'd1;
                    end
                end
                c_ST_DONE: begin
                    r_lcd_e    <= 1'b0;
                    r_lcd_rs   <= 1'b0;
                    r_lcd_data <= 8'h00;
                end
                default: begin
                    r_lcd_e     <= 1'b0;
                    r_lcd_cnt   <= 16'd0;
                    r_lcd_state <= c_ST_PWR_WAIT;
                end
            endcase
        end
    end

    assign LCD_E_PIN     = r_lcd_e;
    assign LCD_RS_PIN    = r_lcd_rs;
    assign LCD_DATA_PINS = r_lcd_data;
`else
    assign LCD_E_PIN     = 1'b0;
    assign LCD_RS_PIN    = 1'b0;
    assign LCD_DATA_PINS = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_niski_dut.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_niski_dut                                                    |
// | Desc     : Directed scoreboard bench for niski_dut (step counter, 7-seg,   |
// |            LEDs, LCD init sequence when NISKI_LCD_EN is defined).          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_niski_dut;

    localparam logic [31:0] c_BASE = 32'h4000_0000;

    logic       clk = 1'b0;
    logic [4:0] btn;
    logic [3:0] led;
    logic [6:0] seg;
    logic [3:0] sel;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;

    niski_dut #(
        .RESET_PC    (32'h4000_0000),
        .END_ADDR    (32'h4000_0538),
        .REFRESH_DIV (16),
        .LCD_DELAY   (16),
        .E_CYCLES    (4)
    ) dut (
        .CLK_PIN         (clk),
        .BTN_PINS        (btn),
        .LED_PINS        (led),
        .SEVSEG_SEG_PINS (seg),
        .SEVSEG_SEL_PINS (sel),
        .LCD_RS_PIN      (lcd_rs),
        .LCD_RW_PIN      (lcd_rw),
        .LCD_E_PIN       (lcd_e),
        .LCD_DATA_PINS   (lcd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n      = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic tick_to(input int target);
        while (n < target) tick(1);
    endtask

    task automatic push_cmds();
        logic [7:0] cmds [4];
        cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            push($sformatf("lcd_data%0d", i), {24'd0, cmds[i]});
            push($sformatf("lcd_rs%0d", i), 32'd0);
            push($sformatf("lcd_rw%0d", i), 32'd0);
            push($sformatf("lcd_hold_data%0d", i), {24'd0, cmds[i]});
            push($sformatf("lcd_e_width%0d", i), 32'd4);
        end
    endtask

    // Pops data/rs/rw on each E rise and held data/width on each E fall.
    task automatic watch_pulses(input int n_exp, input int budget);
        int   seen  = 0;
        int   width = 0;
        logic pe    = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick(1);
            if (lcd_e && !pe) begin
                seen++;
                width = 1;
                if (seen <= n_exp) begin
                    check({24'd0, lcd_data});
                    check({31'd0, lcd_rs});
                    check({31'd0, lcd_rw});
                end
            end else if (lcd_e) begin
                width++;
            end else if (pe && seen <= n_exp) begin
                check({24'd0, lcd_data});
                check(width);
            end
            pe = lcd_e;
        end
        push("lcd_pulse_count", n_exp);
        check(seen);
        push("lcd_done_idle", 32'd0);
        check({21'd0, lcd_e, lcd_rs, lcd_rw, lcd_data});
    endtask

    initial begin
        btn = 5'b01111;
        tick(3);
        push("rst_pc", c_BASE);            check(dut.r_pc);
        push("rst_sel", 32'b1110);         check({28'd0, sel});
        push("rst_seg", 32'b1000000);      check({25'd0, seg});
        push("rst_led", 32'd0);            check({28'd0, led});
        push("rst_lcd", 32'd0);            check({21'd0, lcd_e, lcd_rs, lcd_rw, lcd_data});

        // Release just after an edge; n counts edges from here.
        btn[4] = 1'b1;
        n = 0;
        tick_to(10);  push("pc_run10", c_BASE + 32'h20);   check(dut.r_pc);
        tick_to(72);  btn[3] = 1'b0;
        tick_to(73);  push("led_pause_1cyc", 32'b0000);     check({28'd0, led});
        tick_to(74);  push("led_pause_2cyc", 32'b1000);     check({28'd0, led});
        push("pc_frozen", c_BASE + 32'h120);                check(dut.r_pc);
        push("sel_d0", 32'b1110);                           check({28'd0, sel});
        push("seg_d0", 32'b1000000);                        check({25'd0, seg});
        tick_to(81);  push("sel_d0_last", 32'b1110);        check({28'd0, sel});
        tick_to(82);  push("sel_d1_first", 32'b1101);       check({28'd0, sel});
        tick_to(90);  push("sel_d1", 32'b1101);             check({28'd0, sel});
        push("seg_d1", 32'b0100100);                        check({25'd0, seg});
        tick_to(106); push("sel_d2", 32'b1011);             check({28'd0, sel});
        push("seg_d2", 32'b1111001);                        check({25'd0, seg});
        tick_to(122); push("sel_d3", 32'b0111);             check({28'd0, sel});
        push("seg_d3", 32'b1000000);                        check({25'd0, seg});
        push("pc_frozen_50", c_BASE + 32'h120);             check(dut.r_pc);
        tick_to(124); btn[3] = 1'b1;
        tick_to(126); push("pc_resume_edge", c_BASE + 32'h120); check(dut.r_pc);
        push("led_released", 32'b0000);                     check({28'd0, led});
        tick_to(127); push("pc_resumed", c_BASE + 32'h124); check(dut.r_pc);
        tick_to(128); btn[1] = 1'b0;
        tick_to(130); push("led_user1", 32'b0010);          check({28'd0, led});
        btn[1] = 1'b1;
        tick_to(387); push("pc_before_end", c_BASE + 32'h534); check(dut.r_pc);
        tick_to(388); push("pc_end", c_BASE + 32'h538);     check(dut.r_pc);
        tick_to(408); push("pc_end_hold", c_BASE + 32'h538); check(dut.r_pc);
        push("lcd_rw_low", 32'd0);                          check({31'd0, lcd_rw});

`ifdef NISKI_LCD_EN
        btn[4] = 1'b0;
        tick(3);
        push_cmds();
        btn[4] = 1'b1;
        watch_pulses(4, 250);

        btn[4] = 1'b0;
        tick(3);
        btn[4] = 1'b1;
        begin
            int   rises = 0;
            logic pe    = 1'b0;
            for (int c = 0; c < 300 && rises < 2; c++) begin
                tick(1);
                if (lcd_e && !pe) rises++;
                pe = lcd_e;
            end
            push("lcd_reach_pulse2", 32'd2);
            check(rises);
        end
        tick(1);
        push("lcd_mid_pulse_e", 32'd1);                     check({31'd0, lcd_e});
        btn[4] = 1'b0;
        #1;
        push("lcd_abort_e", 32'd0);                         check({31'd0, lcd_e});
        push("lcd_abort_data", 32'd0);                      check({24'd0, lcd_data});
        tick(3);
        push_cmds();
        btn[4] = 1'b1;
        watch_pulses(4, 250);
`else
        push("lcd_disabled", 32'd0);
        check({21'd0, lcd_e, lcd_rs, lcd_rw, lcd_data});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/niski_dut.md
NISKI_DUT -- requirements
Module: niski_dut

Interface
REQ-001 SHALL have one clock, CLK_PIN; reset is asynchronous and active-low, taken from BTN_PINS[4].
REQ-002 SHALL expose parameters: RESET_PC, 32'h4000_0000, step-counter start address; END_ADDR, 32'h4000_0538, step-counter stop address; REFRESH_DIV, 16, clocks per 7-seg digit; LCD_DELAY, 16, clocks between LCD commands; E_CYCLES, 4, LCD E high width.
REQ-003 CLK_PIN  in  1  system clock, rising edge.
REQ-004 BTN_PINS  in  5  active-low buttons; [4]=reset_n, [3]=pause, [2:0]=user.
REQ-005 LED_PINS  out  4  active-high LEDs.
REQ-006 SEVSEG_SEG_PINS  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-007 SEVSEG_SEL_PINS  out  4  active-low digit selects, [0]=least significant digit.
REQ-008 LCD_RS_PIN, LCD_RW_PIN, LCD_E_PIN  out  1 each  HD44780 control; LCD_DATA_PINS  out  8  LCD data bus.

Function
REQ-009 SHALL synchronise BTN_PINS[3:0] through 2 flops; synced value visible 2 cycles after a pin change.
REQ-010 SHALL drive LED_PINS[3:0] = ~synced BTN_PINS[3:0] (pressed = lit).
REQ-011 SHALL hold internal 32-bit register pc, which adds 4 every cycle while synced BTN_PINS[3] is high and pc != END_ADDR.
REQ-012 SHALL hold pc constant while pause is pressed; stepping resumes on the cycle after synced pause returns high.
REQ-013 SHALL multiplex pc[15:0] as 4 hex digits: digit i = pc[4i+3:4i] on SEL[i]; index advances every REFRESH_DIV cycles, wrapping 3->0.
REQ-014 SHALL encode hex 0-F with standard patterns (e.g. 0=7'b1000000, 1=7'b1111001, 8=7'b0000000); exactly one SEL bit low at any time.
REQ-015 SHALL tie LCD_RW_PIN to 0 (write-only).
REQ-016 SHALL run LCD FSM: PWR_WAIT (LCD_DELAY cycles) -> SETUP (RS, data valid, E low, 1 cycle) -> PULSE (E high, E_CYCLES cycles) -> HOLD (E low, data held, LCD_DELAY cycles) -> SETUP for next command, or DONE after the last.
REQ-017 SHALL send, RS=0, commands 0x38, 0x0C, 0x06, 0x01 in that order; DONE holds E=0, RS=0, data 0x00 until reset.
REQ-018 SHALL keep LCD_DATA_PINS and LCD_RS_PIN stable from SETUP through HOLD of each command.

Reset
REQ-019 SHALL assert reset asynchronously on BTN_PINS[4]=0 and release it synchronously through a 2-flop synchroniser.
REQ-020 Reset values: pc=RESET_PC, LED_PINS=0, digit index 0, SEL=4'b1110, SEG=7'b1000000, LCD_E/RS/RW=0, LCD_DATA=0, LCD FSM in PWR_WAIT, button syncs=1.
REQ-021 SHALL abort any LCD transfer on reset mid-operation (E falls immediately) and restart the sequence from PWR_WAIT.

Configuration
REQ-022 With NISKI_LCD_EN defined, SHALL include the LCD FSM per REQ-016 to REQ-018.
REQ-023 Without NISKI_LCD_EN, SHALL omit the FSM and hold all LCD pins at 0 permanently.

Verification
REQ-024 Reset pulse, all buttons released -> pc=0x4000_0000, SEL=1110, SEG=1000000, LEDs=0000, LCD_E=0.
REQ-025 Run 334 steps after reset release -> pc=0x4000_0538; 20 further cycles -> pc stays 0x4000_0538.
REQ-026 Hold BTN_PINS[3]=0 for 50 cycles mid-run -> pc frozen; LED_PINS[3]=1 two cycles after press.
REQ-027 Observe 4*REFRESH_DIV cycles with pc paused at 0x4000_0120 -> SEL cycles 1110,1101,1011,0111 with SEG 1000000, 0100100, 1111001, 1000000.
REQ-028 NISKI_LCD_EN defined -> exactly 4 E pulses, each E_CYCLES wide, data 0x38, 0x0C, 0x06, 0x01, RS=0, RW=0; assert reset during pulse 2 -> E drops at once, sequence restarts at 0x38.
